repetition_tx: RTL

- Transmit end of the repetition-coded serial link. Its receive end groups chips by REP and resolves each group with the majority function.
- Accepts a parallel word via a valid/ready handshake.
- Serializes the word LSB first, driving each data bit for REP consecutive chips, with downstream backpressure.
- Sits between the word source and the serial channel, or a loopback into the majority receiver.

---
 rtl/rep_link_pkg.sv | 22 ++
 rtl/rep_tx_counter.sv | 50 +++++
 rtl/repetition_tx.sv | 99 +++++++++
 3 files changed

// File: rtl/rep_link_pkg.sv
// Shared definitions for the repetition-coded serial link (transmit and receive ends).
// Holds the FSM state type, default geometry and the counter-width helper.
// Chip grouping on the receive side uses the same REP and width rules.
package rep_link_pkg;

  // Transmitter control states
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Default link geometry: 8-bit words, 3 chips per bit
  localparam int DEF_DATA_W = 8;
  localparam int DEF_REP    = 3;

  // Counter width for counting 0..x-1. Never returns zero, so a
  // degenerate count of 1 still gets a legal 1-bit register.
  function automatic int cnt_width(input int x);
    return (x <= 2) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/rep_tx_counter.sv
// Two-level chip/bit position counter for the repetition transmitter.
// Latency: registered counts, chip_wrap/word_done are combinational from them.
// Backpressure: counts advance only when en (chip consumed) is high, otherwise hold.
module rep_tx_counter
  import rep_link_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REP    = DEF_REP
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic chip_wrap,
  output logic word_done
);

  localparam int RW = cnt_width(REP);
  localparam int BW = cnt_width(DATA_W);

  // Terminal values; counts compare for equality so non-power-of-2
  // REP or DATA_W never run past their last legal value.
  localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  logic [RW-1:0] rep_cnt;
  logic [BW-1:0] bit_cnt;

  assign chip_wrap = (rep_cnt == REP_LAST);
  assign word_done = chip_wrap && (bit_cnt == BIT_LAST);

  // Inner count walks the chips of one bit; outer count walks the bits of the word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_cnt <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      rep_cnt <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      if (chip_wrap) begin
        rep_cnt <= '0;
        bit_cnt <= word_done ? '0 : bit_cnt + BW'(1);
      end else begin
        rep_cnt <= rep_cnt + RW'(1);
      end
    end
  end

endmodule

// File: rtl/repetition_tx.sv
// Repetition-coded serializer: accepts a word, sends each bit LSB first as REP identical chips.
// Latency: first chip is presented the cycle after the word is accepted; DATA_W*REP chips per word.
// Backpressure: tx_ready low freezes chip, counters and shift register; in_ready reopens on the last chip.
module repetition_tx
  import rep_link_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REP    = DEF_REP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_bit,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_last,
  output logic              busy
);

  // The receiver resolves each chip group by majority, so an even group
  // could tie; reject such builds at elaboration.
  if ((REP < 1) || ((REP % 2) == 0)) begin : g_bad_rep
    $error("repetition_tx: REP must be odd and >= 1");
  end
  if (DATA_W < 1) begin : g_bad_width
    $error("repetition_tx: DATA_W must be >= 1");
  end

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] shreg;
  logic              accept;
  logic              consume;
  logic              chip_wrap;
  logic              word_done;

  // Handshake and chip outputs are all decoded from state/counters, so an
  // asynchronous reset drops tx_valid/tx_last/busy in the same cycle.
  assign tx_valid = (state == SEND);
  assign busy     = (state == SEND);
  assign tx_bit   = shreg[0];
  assign tx_last  = tx_valid && word_done;
  assign in_ready = (state == IDLE) || (tx_last && tx_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = tx_valid && tx_ready;

  rep_tx_counter #(
    .DATA_W (DATA_W),
    .REP    (REP)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .en        (consume),
    .chip_wrap (chip_wrap),
    .word_done (word_done)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: a word accepted on the final chip keeps us in SEND with no bubble
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = SEND;
        end
      end
      SEND: begin
        if (consume && word_done) begin
          state_next = accept ? SEND : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Shift register: load on accept, advance one bit after the last chip of each bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
    end else if (accept) begin
      shreg <= in_data;
    end else if (consume && chip_wrap) begin
      shreg <= shreg >> 1;
    end
  end

endmodule
